// File: rtl/wr_spi_pkg.sv
// Shared types and widths for the write-path SPI transmitter (wr_spi_tx) and its byte FIFO.
package wr_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } wr_spi_state_t;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/wr_byte_fifo.sv
// Synchronous byte FIFO; dout is the head entry, combinational. Pushes when full and pops
// when empty are ignored here, so the caller owns overflow reporting.
module wr_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wr_spi_tx.sv
// Buffers the upstream wr_en/wr_data byte stream and sends it on a mode-0 SPI link, keeping CS_n
// low across back-to-back bytes. Define WR_SPI_LSB_FIRST_EN to send bit0 first instead of bit7.
module wr_spi_tx
    import wr_spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_HOLD    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    output logic              fifo_full,
    output logic              tx_busy,
    output logic              ovf,
    output wr_spi_state_t     dbg_state
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(CS_HOLD - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = '1;

`ifdef WR_SPI_LSB_FIRST_EN
    function automatic logic lead_bit(input logic [BYTE_W-1:0] b);
        return b[0];
    endfunction
    function automatic logic [BYTE_W-1:0] advance(input logic [BYTE_W-1:0] b);
        return {1'b0, b[BYTE_W-1:1]};
    endfunction
`else
    function automatic logic lead_bit(input logic [BYTE_W-1:0] b);
        return b[BYTE_W-1];
    endfunction
    function automatic logic [BYTE_W-1:0] advance(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0};
    endfunction
`endif

    wr_spi_state_t          r_state;
    logic [DIV_W-1:0]       r_div;
    logic [HOLD_W-1:0]      r_hold;
    logic [BIT_CNT_W-1:0]   r_bit;
    logic [BYTE_W-1:0]      r_shift;
    logic                   r_sclk;
    logic                   r_cs_n;
    logic                   r_mosi;
    logic                   r_ovf;

    logic [BYTE_W-1:0]      w_fifo_dout;
    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_div_done;
    logic                   w_byte_end;
    logic                   w_pop;
    logic [BYTE_W-1:0]      w_next_shift;

    // wr_en has no ready: a byte offered while the FIFO is full is lost and flagged on ovf.
    wr_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_fifo_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_div_done   = (r_div == DIV_LAST);
    assign w_byte_end   = (r_state == SHIFT) && w_div_done && r_sclk && (r_bit == BIT_LAST);
    assign w_pop        = !w_empty && ((r_state == IDLE) || w_byte_end);
    assign w_next_shift = advance(r_shift);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_hold  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_fifo_dout;
                        r_mosi  <= lead_bit(w_fifo_dout);
                        r_cs_n  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_div_done) begin
                        r_div   <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (w_div_done) begin
                        r_div  <= '0;
                        r_sclk <= !r_sclk;
                        // Falling edge: either advance within the byte or close it out.
                        if (r_sclk) begin
                            if (r_bit == BIT_LAST) begin
                                if (!w_empty) begin
                                    r_shift <= w_fifo_dout;
                                    r_mosi  <= lead_bit(w_fifo_dout);
                                    r_bit   <= '0;
                                end else begin
                                    r_hold  <= '0;
                                    r_state <= HOLD;
                                end
                            end else begin
                                r_bit   <= r_bit + BIT_CNT_W'(1);
                                r_shift <= w_next_shift;
                                r_mosi  <= lead_bit(w_next_shift);
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_cs_n  <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (wr_en && w_full) begin
            r_ovf <= 1'b1;
        end
    end

    assign spi_sclk  = r_sclk;
    assign spi_cs_n  = r_cs_n;
    assign spi_mosi  = r_mosi;
    assign fifo_full = w_full;
    assign tx_busy   = (r_state != IDLE) || (w_count != '0);
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_wr_spi_tx.sv
// Self-checking bench for wr_spi_tx: directed scenarios plus random write traffic, checked each
// cycle against a timeline model of FIFO occupancy and SPI frame timing.
module tb_wr_spi_tx;
    import wr_spi_pkg::*;

    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 4;
    localparam int CS_HOLD = 2;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          spi_sclk;
    logic          spi_cs_n;
    logic          spi_mosi;
    logic          fifo_full;
    logic          tx_busy;
    logic          ovf;
    wr_spi_state_t dbg_state;

    wr_spi_tx #(
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (CLK_DIV),
        .CS_HOLD    (CS_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .spi_sclk  (spi_sclk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_mosi),
        .fifo_full (fifo_full),
        .tx_busy   (tx_busy),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Timeline view: each byte occupies 16*CLK_DIV edges from its pop; after the last byte the
    // frame holds CS_HOLD edges, and the next pop may happen one edge after CS_n rises.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         m_idle_ok = 0;
    int         m_byte_start = 0;
    int         m_byte_end = 0;
    int         m_cb;
    bit         m_active = 0;
    bit         m_pop;
    bit         m_ovf = 0;
    logic [7:0] m_cur = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mq.delete();
                exp_q.delete();
                m_active  = 0;
                m_idle_ok = 0;
                m_ovf     = 0;
            end else begin
                cyc++;
                m_cb  = mq.size();
                m_pop = 0;
                if (!m_active) begin
                    if (cyc >= m_idle_ok && m_cb > 0) m_pop = 1;
                end else if (cyc == m_byte_end) begin
                    if (m_cb > 0) m_pop = 1;
                    else begin
                        m_active  = 0;
                        m_idle_ok = cyc + CS_HOLD + 1;
                    end
                end
                if (m_pop) begin
                    m_cur = mq.pop_front();
                    exp_q.push_back(m_cur);
                    m_active     = 1;
                    m_byte_start = cyc;
                    m_byte_end   = cyc + 16 * CLK_DIV;
                end
                if (wr_en) begin
                    if (m_cb < DEPTH) mq.push_back(wr_data);
                    else m_ovf = 1;
                end
            end
        end
    end

    function automatic bit model_idle();
        return !m_active && (cyc >= m_idle_ok) && (mq.size() == 0);
    endfunction

    // ---------------- per-cycle checker and SPI receiver ----------------
    int         rx_idx = 0;
    int         rx_n = 0;
    logic [7:0] rx_byte = '0;
    logic       prev_sclk = 1'b0;
    int         o;
    int         j;
    logic       e_cs_n;
    logic       e_sclk;
    logic       e_mosi;
    logic       e_busy;
    logic       e_full;

    initial begin
        forever begin
            @(negedge clk);
            e_cs_n = !(m_active || (cyc < m_idle_ok - 1));
            e_sclk = 1'b0;
            e_mosi = 1'b0;
            if (m_active) begin
                o = cyc - m_byte_start;
                j = o / (2 * CLK_DIV);
                e_sclk = (o >= CLK_DIV) && (((o / CLK_DIV) % 2) == 1);
`ifdef WR_SPI_LSB_FIRST_EN
                e_mosi = m_cur[j];
`else
                e_mosi = m_cur[7 - j];
`endif
            end
            e_busy = !e_cs_n || (mq.size() > 0);
            e_full = (mq.size() == DEPTH);
            check("cs_n", 32'(spi_cs_n), 32'(e_cs_n));
            check("sclk", 32'(spi_sclk), 32'(e_sclk));
            check("tx_busy", 32'(tx_busy), 32'(e_busy));
            check("fifo_full", 32'(fifo_full), 32'(e_full));
            check("ovf", 32'(ovf), 32'(m_ovf));
            if (m_active) check("mosi", 32'(spi_mosi), 32'(e_mosi));
            if (!reset) begin
                check("reset_mosi", 32'(spi_mosi), 32'd0);
                check("reset_state", 32'(dbg_state), 32'(IDLE));
                rx_idx    = 0;
                rx_n      = 0;
                prev_sclk = 1'b0;
            end else begin
                if (spi_sclk && !prev_sclk) begin
`ifdef WR_SPI_LSB_FIRST_EN
                    rx_byte = {spi_mosi, rx_byte[7:1]};
`else
                    rx_byte = {rx_byte[6:0], spi_mosi};
`endif
                    rx_n++;
                    if (rx_n == 8) begin
                        if (rx_idx < exp_q.size()) check("rx_byte", 32'(rx_byte), 32'(exp_q[rx_idx]));
                        else check("rx_extra_byte", 32'(rx_byte), 32'hFFFF_FFFF);
                        rx_idx++;
                        rx_n = 0;
                    end
                end
                prev_sclk = spi_sclk;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!model_idle() && n < budget) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("drain_busy", 32'(tx_busy), 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int base;
    int rate;

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;

        // Reset held with wr_en toggling: outputs must stay idle.
        repeat (8) begin
            tick();
            wr_en   = 1'($urandom_range(0, 1));
            wr_data = 8'($urandom_range(0, 255));
        end
        tick();
        wr_en = 1'b0;
        reset = 1'b1;
        tick();

        // Single byte, then a back-to-back burst in one frame.
        send(8'hA5);
        drain(300);
        check("single_rx_count", 32'(rx_idx), 32'd1);
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        drain(600);
        check("burst_rx_count", 32'(rx_idx), 32'd4);

        // Overflow: 18 consecutive writes into a 16-deep FIFO.
        base = rx_idx;
        for (int i = 0; i < 18; i++) send(8'(i));
        check("ovf_set", 32'(ovf), 32'd1);
        drain(2000);
        check("ovf_rx_count", 32'(rx_idx - base), 32'd17);
        check("ovf_sticky", 32'(ovf), 32'd1);
        pulse_reset();
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Reset during bit 4 of the first byte of a 3-byte burst.
        send(8'h3C);
        send(8'hC3);
        send(8'h5A);
        repeat (9 * CLK_DIV - 1) tick();
        reset = 1'b0;
        #1;
        check("abort_cs_n", 32'(spi_cs_n), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        repeat (40) tick();
        check("abort_busy", 32'(tx_busy), 32'd0);
        check("abort_full", 32'(fifo_full), 32'd0);

        // Random traffic at several write rates, one asynchronous reset in the middle.
        for (int blk = 0; blk < 6; blk++) begin
            rate = (blk % 3 == 0) ? 8 : ((blk % 3 == 1) ? 45 : 100);
            for (int c = 0; c < 400; c++) begin
                wr_en   = 1'($urandom_range(0, 99) < rate);
                wr_data = 8'($urandom);
                if (blk == 4 && c == 150) begin
                    wr_en = 1'b0;
                    pulse_reset();
                end else begin
                    tick();
                end
            end
            wr_en = 1'b0;
            if (blk == 2) drain(3000);
        end
        drain(3000);
        check("final_rx_count", 32'(rx_idx), 32'(exp_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
